// File: rtl/id_hazard_ctrl.sv
// Purpose : decode-stage operand resolver plus load-use hazard scoreboard for the RV32I pipe.
// Latency : operands and stall request are combinational (0 cycles); scoreboard updates per clk edge.
// Backpr. : raises stallreq_o while a read source is waiting on a load; issues during a stall are ignored.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rs1_i/rs2_i, rs*_re_i        source register addresses and read enables
//   reg1_rdata_i/reg2_rdata_i    register-file read data
//   issue_i, issue_is_load_i,
//   issue_rd_i                   ID instruction leaving for EXE, load flag, destination
//   fwd_we_i/waddr_i/wdata_i     NUM_FWD forwarding sources, source k at [k*W +: W], 0 = youngest
//   op1_o/op2_o                  resolved operands
//   stallreq_o                   load-use stall request
//   stall_cnt_o                  stall-cycle counter
//
// Optional feature: define ID_STALL_PERF_EN to build the saturating stall-cycle counter;
// otherwise stall_cnt_o is tied to zero and no counter flops exist.

module id_hazard_ctrl #(
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned RDATA_WIDTH = 32,
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned LOAD_LAT    = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [RADDR_WIDTH-1:0]         rs1_i,
  input  logic [RADDR_WIDTH-1:0]         rs2_i,
  input  logic                           rs1_re_i,
  input  logic                           rs2_re_i,
  input  logic [RDATA_WIDTH-1:0]         reg1_rdata_i,
  input  logic [RDATA_WIDTH-1:0]         reg2_rdata_i,
  input  logic                           issue_i,
  input  logic                           issue_is_load_i,
  input  logic [RADDR_WIDTH-1:0]         issue_rd_i,
  input  logic [NUM_FWD-1:0]             fwd_we_i,
  input  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*RDATA_WIDTH-1:0] fwd_wdata_i,
  output logic [RDATA_WIDTH-1:0]         op1_o,
  output logic [RDATA_WIDTH-1:0]         op2_o,
  output logic                           stallreq_o,
  output logic [31:0]                    stall_cnt_o
);

  localparam int unsigned NREG = 1 << RADDR_WIDTH;
  localparam int unsigned CW   = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] ARM_VAL = CW'(LOAD_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // A load must still be visible on some forwarding source when its countdown expires:
  // after LOAD_LAT cycles it sits in source LOAD_LAT.
  if (LOAD_LAT < 1) begin : g_chk_lat
    $error("id_hazard_ctrl: LOAD_LAT must be >= 1");
  end
  if (NUM_FWD < LOAD_LAT + 1) begin : g_chk_fwd
    $error("id_hazard_ctrl: NUM_FWD must be >= LOAD_LAT+1");
  end

  // --------------------------------------------------------------------------
  // Load scoreboard: cnt[r] = cycles until the load writing r becomes forwardable
  // --------------------------------------------------------------------------
  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic          arm;
  logic          rs1_hz;
  logic          rs2_hz;

  // A stalled issue is not really leaving ID, so it must not arm the scoreboard.
  assign arm = issue_i & issue_is_load_i & ~stallreq_o & (issue_rd_i != '0);

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CNT_ONE) : '0;
      // Re-arm beats the decrement of the same entry.
      if (arm && (issue_rd_i == RADDR_WIDTH'(r))) begin
        cnt_d[r] = ARM_VAL;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_q[r] <= rst_i ? '0 : cnt_d[r];
    end
  end

  assign rs1_hz     = rs1_re_i & (cnt_q[rs1_i] != '0);
  assign rs2_hz     = rs2_re_i & (cnt_q[rs2_i] != '0);
  assign stallreq_o = ~rst_i & (rs1_hz | rs2_hz);

  // --------------------------------------------------------------------------
  // Operand resolution: youngest matching forwarding source wins over the regfile
  // --------------------------------------------------------------------------
  function automatic logic [RDATA_WIDTH-1:0] resolve(
    input logic                           rst,
    input logic                           re,
    input logic [RADDR_WIDTH-1:0]         rs,
    input logic [RDATA_WIDTH-1:0]         rf,
    input logic [NUM_FWD-1:0]             we,
    input logic [NUM_FWD*RADDR_WIDTH-1:0] wa,
    input logic [NUM_FWD*RDATA_WIDTH-1:0] wd
  );
    logic [RDATA_WIDTH-1:0] v;
    v = rf;
    // Walk oldest to youngest so the lowest matching index is the last write.
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      if (we[k] && (wa[k*RADDR_WIDTH +: RADDR_WIDTH] == rs)) begin
        v = wd[k*RDATA_WIDTH +: RDATA_WIDTH];
      end
    end
    // x0 is hard zero even if some stage claims to write it.
    if (rst || !re || (rs == '0)) begin
      v = '0;
    end
    return v;
  endfunction

  assign op1_o = resolve(rst_i, rs1_re_i, rs1_i, reg1_rdata_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i);
  assign op2_o = resolve(rst_i, rs2_re_i, rs2_i, reg2_rdata_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i);

  // --------------------------------------------------------------------------
  // Stall-cycle performance counter (saturating)
  // --------------------------------------------------------------------------
`ifdef ID_STALL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallreq_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

  localparam int LAT = 3;
  localparam int NF  = 4;
  localparam int A   = 5;
  localparam int W   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [A-1:0]  rs1, rs2, rd;
  logic          re1, re2;
  logic [W-1:0]  reg1, reg2;
  logic          issue, is_load;
  logic [NF-1:0] fwe;
  logic [A-1:0]  fa [NF];
  logic [W-1:0]  fd [NF];
  logic [NF*A-1:0] fwd_waddr;
  logic [NF*W-1:0] fwd_wdata;
  logic [W-1:0]  op1_o, op2_o;
  logic          stallreq_o;
  logic [31:0]   stall_cnt_o;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: edge number at which each register's load issued.
  longint      issue_t [32];
  longint      edge_n = 0;
  logic [31:0] m_cnt  = 0;

  always #5 clk = ~clk;

  always_comb begin
    fwd_waddr = '0;
    fwd_wdata = '0;
    for (int k = 0; k < NF; k++) begin
      fwd_waddr[k*A +: A] = fa[k];
      fwd_wdata[k*W +: W] = fd[k];
    end
  end

  id_hazard_ctrl #(
    .RADDR_WIDTH(A), .RDATA_WIDTH(W), .NUM_FWD(NF), .LOAD_LAT(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .rs1_i(rs1), .rs2_i(rs2), .rs1_re_i(re1), .rs2_re_i(re2),
    .reg1_rdata_i(reg1), .reg2_rdata_i(reg2),
    .issue_i(issue), .issue_is_load_i(is_load), .issue_rd_i(rd),
    .fwd_we_i(fwe), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
    .op1_o(op1_o), .op2_o(op2_o), .stallreq_o(stallreq_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A register is busy while fewer than LAT edges have passed since its load issued.
  function automatic logic busy(input logic [A-1:0] r);
    return (r != 0) && ((edge_n - issue_t[r]) < LAT);
  endfunction

  function automatic logic m_stall();
    return !rst && ((re1 && busy(rs1)) || (re2 && busy(rs2)));
  endfunction

  function automatic logic [W-1:0] m_op(input logic re, input logic [A-1:0] rs, input logic [W-1:0] rf);
    if (rst || !re || rs == 0) return '0;
    for (int k = 0; k < NF; k++)
      if (fwe[k] && fa[k] == rs) return fd[k];
    return rf;
  endfunction

  // Check the current cycle against the model, then advance one clock.
  task automatic step(output logic st, output logic [W-1:0] o1, output logic [W-1:0] o2);
    logic        exp_st;
    logic [31:0] exp_cnt;
    #1;
    exp_st = m_stall();
`ifdef ID_STALL_PERF_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'd0;
`endif
    chk("stallreq", {31'b0, stallreq_o}, {31'b0, exp_st});
    chk("op1", op1_o, m_op(re1, rs1, reg1));
    chk("op2", op2_o, m_op(re2, rs2, reg2));
    chk("stall_cnt", stall_cnt_o, exp_cnt);
    st = stallreq_o;
    o1 = op1_o;
    o2 = op2_o;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      foreach (issue_t[i]) issue_t[i] = -100;
      m_cnt = 0;
    end else begin
      if (exp_st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (issue && is_load && !exp_st && rd != 0) issue_t[rd] = edge_n;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; issue = 0; is_load = 0; rd = 0;
    re1 = 0; re2 = 0; rs1 = 0; rs2 = 0;
    reg1 = 32'hAAAA_0001; reg2 = 32'hBBBB_0002;
    fwe = '0;
    for (int k = 0; k < NF; k++) begin fa[k] = 0; fd[k] = 0; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        st;
    logic [W-1:0] o1, o2;
    int          n;

    foreach (issue_t[i]) issue_t[i] = -100;
    idle_inputs();
    rst = 1;
    @(posedge clk);
    @(negedge clk);

    // Reset with reads and all sources forwarding the read register.
    re1 = 1; re2 = 1; rs1 = 5; rs2 = 6; fwe = '1;
    for (int k = 0; k < NF; k++) begin fa[k] = 5; fd[k] = 32'h5555_0000 + k; end
    for (int i = 0; i < 2; i++) begin
      step(st, o1, o2);
      chk("rst_op1", o1, 0);
      chk("rst_op2", o2, 0);
      chk("rst_stall", {31'b0, st}, 0);
    end

    // Load x5, then reader of x5 on rs2: LAT stalls, released with source LAT data.
    idle_inputs();
    issue = 1; is_load = 1; rd = 5;
    step(st, o1, o2);
    idle_inputs();
    re2 = 1; rs2 = 5; rs1 = 7; re1 = 1;
    fwe[LAT] = 1; fa[LAT] = 5; fd[LAT] = 32'hDEAD_BEEF;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(st, o1, o2);
      if (!st) break;
      n++;
    end
    chk("ld_use_stalls", 32'(n), LAT);
    chk("ld_use_op2", o2, 32'hDEAD_BEEF);
`ifdef ID_STALL_PERF_EN
    chk("ld_use_cnt", stall_cnt_o, LAT);
`else
    chk("ld_use_cnt", stall_cnt_o, 0);
`endif

    // Priority between sources, and x0 never forwarded.
    idle_inputs();
    re1 = 1; rs1 = 9; fwe = 4'b0011;
    fa[0] = 9; fd[0] = 32'h11; fa[1] = 9; fd[1] = 32'h22;
    step(st, o1, o2);
    chk("fwd_prio", o1, 32'h11);
    rs1 = 0; fa[0] = 0; fa[1] = 0;
    step(st, o1, o2);
    chk("fwd_x0", o1, 0);

    // Back-to-back loads to x5 re-arm the countdown.
    idle_inputs();
    issue = 1; is_load = 1; rd = 5;
    step(st, o1, o2);
    step(st, o1, o2);
    idle_inputs();
    re1 = 1; rs1 = 5;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(st, o1, o2);
      if (!st) break;
      n++;
    end
    chk("rearm_stalls", 32'(n), LAT);

    // Reset right after a load clears its hazard.
    idle_inputs();
    issue = 1; is_load = 1; rd = 5;
    step(st, o1, o2);
    idle_inputs();
    rst = 1;
    step(st, o1, o2);
    idle_inputs();
    re1 = 1; rs1 = 5; reg1 = 32'h1234;
    step(st, o1, o2);
    chk("rst_mid_stall", {31'b0, st}, 0);
    chk("rst_mid_op1", o1, 32'h1234);

    // Randomized traffic on a small register set to provoke hazards and matches.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      rs1     = A'($urandom_range(0, 7));
      rs2     = A'($urandom_range(0, 7));
      re1     = ($urandom_range(0, 9) != 0);
      re2     = ($urandom_range(0, 9) > 2);
      reg1    = $urandom;
      reg2    = $urandom;
      issue   = ($urandom_range(0, 2) != 0);
      is_load = ($urandom_range(0, 1) != 0);
      rd      = A'($urandom_range(0, 7));
      fwe     = NF'($urandom);
      for (int k = 0; k < NF; k++) begin
        fa[k] = A'($urandom_range(0, 7));
        fd[k] = $urandom;
      end
      step(st, o1, o2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
